uart_rx_oversampled: RTL and testbench

//   UART receiver: the consuming end of the baud tick produced by BaudRate_Generator.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_sync.sv | 26 ++
 rtl/uart_rx_oversampled.sv | 160 ++++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// UART shared definitions: FSM state encoding and oversampling constants,
// common to the receiver and the planned transmitter.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;  // s_tick pulses per bit period
  localparam int unsigned MID_SAMPLE = 7;   // start-bit tick index that lands mid-bit

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx pad.
// Both flops reset to 1 so the line reads idle while reset is held.
//   clk   in  system clock
//   reset in  asynchronous, active-high
//   d     in  asynchronous serial input
//   q     out synchronized copy of d
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_oversampled.sv
// UART receiver with 16x oversampling. Recovers LSB-first frames
// (start, DBIT data, optional parity, stop) from rx and strobes each word.
//   clk           in   system clock, rising edge
//   reset         in   asynchronous, active-high
//   s_tick        in   one-clk pulse at 16x baud
//   rx            in   asynchronous serial line, idle high
//   rx_dout       out  last received word, LSB first on the line
//   rx_done_tick  out  one-clk strobe: rx_dout and error flags valid
//   parity_err    out  parity mismatch on last frame
//   frame_err     out  stop bit sampled low on last frame
//   rx_busy       out  receiver not idle
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned SB_TICK    = 16,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] rx_dout,
  output logic            rx_done_tick,
  output logic            parity_err,
  output logic            frame_err,
  output logic            rx_busy
);

  localparam int unsigned N_W = (DBIT > 1) ? $clog2(DBIT) : 1;
  // Stop periods longer than one bit need a wider oversample counter.
  localparam int unsigned S_W = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : $clog2(OVERSAMPLE);
  localparam logic PAR_EN  = (PARITY_EN != 0);
  localparam logic PAR_ODD = (PARITY_ODD != 0);

  uart_state_t     state_q, state_n;
  logic [S_W-1:0]  s_q, s_n;
  logic [N_W-1:0]  n_q, n_n;
  logic [DBIT-1:0] b_q, b_n;
  logic            p_q, p_n;
  logic [DBIT-1:0] dout_n;
  logic            done_n, fe_n, pe_n, busy_n;
  logic            rx_s;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      s_q          <= '0;
      n_q          <= '0;
      b_q          <= '0;
      p_q          <= 1'b0;
      rx_dout      <= '0;
      rx_done_tick <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      state_q      <= state_n;
      s_q          <= s_n;
      n_q          <= n_n;
      b_q          <= b_n;
      p_q          <= p_n;
      rx_dout      <= dout_n;
      rx_done_tick <= done_n;
      parity_err   <= pe_n;
      frame_err    <= fe_n;
      rx_busy      <= busy_n;
    end
  end

  // Next-state and datapath; counters only move on s_tick.
  always_comb begin
    state_n = state_q;
    s_n     = s_q;
    n_n     = n_q;
    b_n     = b_q;
    p_n     = p_q;
    dout_n  = rx_dout;
    done_n  = 1'b0;
    fe_n    = frame_err;
    pe_n    = parity_err;

    unique case (state_q)
      IDLE: begin
        // Start edge is taken immediately, not on a tick.
        if (!rx_s) begin
          state_n = START;
          s_n     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == S_W'(MID_SAMPLE)) begin
            if (!rx_s) begin
              state_n = DATA;
              s_n     = '0;
              n_n     = '0;
            end else begin
              state_n = IDLE;  // start pulse too short: glitch
            end
          end else begin
            s_n = s_q + S_W'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == S_W'(OVERSAMPLE - 1)) begin
            b_n = {rx_s, b_q[DBIT-1:1]};
            s_n = '0;
            if (n_q == N_W'(DBIT - 1)) begin
              state_n = PAR_EN ? PARITY : STOP;
            end else begin
              n_n = n_q + N_W'(1);
            end
          end else begin
            s_n = s_q + S_W'(1);
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (s_q == S_W'(OVERSAMPLE - 1)) begin
            p_n     = rx_s;
            s_n     = '0;
            state_n = STOP;
          end else begin
            s_n = s_q + S_W'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_q == S_W'(SB_TICK - 1)) begin
            state_n = IDLE;
            dout_n  = b_q;
            fe_n    = ~rx_s;
            pe_n    = PAR_EN & (p_q != ((^b_q) ^ PAR_ODD));
            done_n  = 1'b1;
          end else begin
            s_n = s_q + S_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
module tb_uart_rx_oversampled;

  localparam int BIT = 160;  // clk per bit: s_tick every 10 clk, 16 ticks per bit

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick;
  logic       rx, rx_p;
  logic [7:0] dout0, dout1;
  logic       done0, done1, pe0, pe1, fe0, fe1, busy0, busy1;

  int   tcnt = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   cnt0 = 0, cnt1 = 0;
  logic prev0 = 1'b0, prev1 = 1'b0;
  time  t_start0, t_strobe0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  // Baud tick source: one-clk pulse every 10 clk.
  always @(posedge clk) tcnt <= (tcnt == 9) ? 0 : tcnt + 1;
  assign s_tick = (tcnt == 9);

  uart_rx_oversampled #(.DBIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .rx           (rx),
    .rx_dout      (dout0),
    .rx_done_tick (done0),
    .parity_err   (pe0),
    .frame_err    (fe0),
    .rx_busy      (busy0)
  );

  uart_rx_oversampled #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .rx           (rx_p),
    .rx_dout      (dout1),
    .rx_done_tick (done1),
    .parity_err   (pe1),
    .frame_err    (fe1),
    .rx_busy      (busy1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Scoreboard pop on each strobe.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && done0) begin
      if (prev0) check("dut0 strobe width", 32'd2, 32'd1);
      if (q0.size() == 0) check("dut0 spurious strobe", {24'd0, dout0}, 32'hFFFF_FFFF);
      else begin
        e = q0.pop_front();
        check("dut0 rx_dout", 32'(dout0), 32'(e.d));
        check("dut0 frame_err", 32'(fe0), 32'(e.fe));
        check("dut0 parity_err", 32'(pe0), 32'(e.pe));
      end
      cnt0++;
      t_strobe0 = $time;
    end
    if (!reset && done1) begin
      if (prev1) check("dut1 strobe width", 32'd2, 32'd1);
      if (q1.size() == 0) check("dut1 spurious strobe", {24'd0, dout1}, 32'hFFFF_FFFF);
      else begin
        e = q1.pop_front();
        check("dut1 rx_dout", 32'(dout1), 32'(e.d));
        check("dut1 frame_err", 32'(fe1), 32'(e.fe));
        check("dut1 parity_err", 32'(pe1), 32'(e.pe));
      end
      cnt1++;
    end
    prev0 = done0;
    prev1 = done1;
  end

  task automatic hold(input int sel, input logic v, input int cyc);
    if (sel == 0) rx = v;
    else rx_p = v;
    repeat (cyc) @(negedge clk);
  endtask

  // stop_low > 0: stop bit held low that many clk (covering the mid-bit
  // sample) then released, so the re-armed start check sees an idle line.
  task automatic send_frame(input int sel, input logic [7:0] d, input logic par, input int stop_low);
    exp_t e;
    e.d  = d;
    e.fe = (stop_low > 0);
    e.pe = (sel == 1) ? (par != ^d) : 1'b0;
    if (sel == 0) begin
      q0.push_back(e);
      t_start0 = $time;
    end else begin
      q1.push_back(e);
    end
    hold(sel, 1'b0, BIT);
    for (int i = 0; i < 8; i++) hold(sel, d[i], BIT);
    if (sel == 1) hold(sel, par, BIT);
    if (stop_low > 0) begin
      hold(sel, 1'b0, stop_low);
      hold(sel, 1'b1, BIT - stop_low);
    end else begin
      hold(sel, 1'b1, BIT);
    end
  endtask

  task automatic wait_strobes(input int sel, input int target);
    int k = 0;
    while (((sel == 0) ? cnt0 : cnt1) < target && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check((sel == 0) ? "dut0 strobe count" : "dut1 strobe count",
          32'((sel == 0) ? cnt0 : cnt1), 32'(target));
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    reset = 1'b1;
    rx    = 1'b1;
    rx_p  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset rx_dout", 32'(dout0), 32'd0);
    check("reset done", 32'(done0), 32'd0);
    check("reset frame_err", 32'(fe0), 32'd0);
    check("reset parity_err", 32'(pe0), 32'd0);
    check("reset busy", 32'(busy0), 32'd0);
    check("reset dut1 busy", 32'(busy1), 32'd0);
    reset = 1'b0;
    hold(0, 1'b1, 200);

    // Single 8N1 frame and its latency from the start edge.
    send_frame(0, 8'hA5, 1'b0, 0);
    wait_strobes(0, 1);
    lat = int'((t_strobe0 - t_start0) / 10);
    check("strobe latency window", 32'(lat >= 1505 && lat <= 1535), 32'd1);
    check("busy after frame", 32'(busy0), 32'd0);

    // Back-to-back frames with no idle gap.
    send_frame(0, 8'h00, 1'b0, 0);
    send_frame(0, 8'hFF, 1'b0, 0);
    send_frame(0, 8'h3C, 1'b0, 0);
    wait_strobes(0, 4);
    hold(0, 1'b1, 320);

    // Short low glitch: no strobe, back to idle.
    hold(0, 1'b0, 48);
    hold(0, 1'b1, 400);
    check("glitch no strobe", 32'(cnt0), 32'd4);
    check("glitch busy", 32'(busy0), 32'd0);

    // Bad stop bit, then a good frame clears frame_err.
    send_frame(0, 8'h55, 1'b0, 100);
    hold(0, 1'b1, 320);
    wait_strobes(0, 5);
    check("frame_err held", 32'(fe0), 32'd1);
    send_frame(0, 8'h96, 1'b0, 0);
    wait_strobes(0, 6);
    check("frame_err cleared", 32'(fe0), 32'd0);

    // Even parity on the parity-enabled instance.
    send_frame(1, 8'h07, 1'b1, 0);
    send_frame(1, 8'h07, 1'b0, 0);
    wait_strobes(1, 2);
    check("parity_err held", 32'(pe1), 32'd1);

    // Reset in the middle of data bit 4 of 0x81.
    hold(0, 1'b0, BIT);
    hold(0, 1'b1, BIT);
    hold(0, 1'b0, BIT);
    hold(0, 1'b0, BIT);
    hold(0, 1'b0, BIT);
    hold(0, 1'b0, 80);
    check("busy mid frame", 32'(busy0), 32'd1);
    reset = 1'b1;
    rx    = 1'b1;
    #1;
    check("midreset rx_dout", 32'(dout0), 32'd0);
    check("midreset frame_err", 32'(fe0), 32'd0);
    check("midreset busy", 32'(busy0), 32'd0);
    check("midreset done", 32'(done0), 32'd0);
    check("midreset dut1 rx_dout", 32'(dout1), 32'd0);
    check("midreset dut1 parity_err", 32'(pe1), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    hold(0, 1'b1, 1600);
    check("aborted frame no strobe", 32'(cnt0), 32'd6);
    send_frame(0, 8'h42, 1'b0, 0);
    wait_strobes(0, 7);
    check("busy final", 32'(busy0), 32'd0);

    check("dut0 scoreboard drained", 32'(q0.size()), 32'd0);
    check("dut1 scoreboard drained", 32'(q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
